// File: rtl/x_mac_column.sv
// x_mac_column: four-row MAC engine behind the X shift buffer. Rotates the
// buffer once per consumed coefficient and emits one result column per 8 products.
module x_mac_column #(
  parameter int N_COLS = 4,
  parameter int ACC_W  = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       x_r1,
  input  logic [7:0]       x_r2,
  input  logic [7:0]       x_r3,
  input  logic [7:0]       x_r4,
  input  logic [7:0]       coef,
  input  logic             coef_valid,
  output logic             x_shift,
  output logic             coef_ready,
  output logic [ACC_W-1:0] res_r1,
  output logic [ACC_W-1:0] res_r2,
  output logic [ACC_W-1:0] res_r3,
  output logic [ACC_W-1:0] res_r4,
  output logic             res_valid,
  output logic [3:0]       col_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       k_reg;
  logic [3:0]       col_reg;
  logic             last_col;
  logic             launch;
  logic [7:0]       x_row   [4];
  logic [ACC_W-1:0] res_row [4];

  assign x_row[0] = x_r1;
  assign x_row[1] = x_r2;
  assign x_row[2] = x_r3;
  assign x_row[3] = x_r4;

  assign res_r1 = res_row[0];
  assign res_r2 = res_row[1];
  assign res_r3 = res_row[2];
  assign res_r4 = res_row[3];

  assign last_col   = (col_reg == 4'(N_COLS - 1));
  assign launch     = (state_reg == IDLE) && start;
  assign coef_ready = x_shift;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    x_shift    = 1'b0;
    busy       = 1'b0;
    case (state_reg)
      IDLE: if (start) state_next = ACCUM;
      ACCUM: begin
        busy    = 1'b1;
        x_shift = coef_valid;
        if (coef_valid && (k_reg == 3'd7) && last_col) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // k wraps 7 -> 0 naturally, which is exactly when the buffer is back at column 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_reg     <= 3'd0;
      col_reg   <= 4'd0;
      col_idx   <= 4'd0;
      res_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      done      <= 1'b0;
      if (launch) begin
        k_reg   <= 3'd0;
        col_reg <= 4'd0;
      end else if (x_shift) begin
        k_reg <= k_reg + 3'd1;
        if (k_reg == 3'd7) begin
          res_valid <= 1'b1;
          col_idx   <= col_reg;
          if (last_col) done    <= 1'b1;
          else          col_reg <= col_reg + 4'd1;
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
      logic [15:0]      prod;
      logic [ACC_W-1:0] sum;
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] res_reg;

      assign prod         = {8'd0, x_row[gi]} * {8'd0, coef};
      assign sum          = acc_reg + {{(ACC_W-16){1'b0}}, prod};
      assign res_row[gi]  = res_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          acc_reg <= '0;
          res_reg <= '0;
        end else if (launch) begin
          acc_reg <= '0;
        end else if (x_shift) begin
          if (k_reg == 3'd7) begin
            res_reg <= sum;
            acc_reg <= '0;
          end else begin
            acc_reg <= sum;
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_x_mac_column.sv
// Bench for x_mac_column: a one-column instance driven from a vector table and
// a four-column instance driven by hand sequences; results checked via scoreboards.
module tb_x_mac_column;
  localparam int AW = 19;

  typedef struct {
    logic [3:0][7:0]    x;
    logic [7:0]         c;
    bit                 stall;
    int                 sbusy;
    int                 lat;
    logic [3:0][AW-1:0] r;
  } vec_t;

  typedef struct {
    logic [3:0][AW-1:0] r;
    logic [3:0]         idx;
    logic               last;
    int                 cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start4 = 1'b0;
  logic [7:0] x1 = '0, x2 = '0, x3 = '0, x4 = '0, coef = '0;
  logic coef_valid = 1'b0;

  logic xs1, cr1, rv1, busy1, done1;
  logic xs4, cr4, rv4, busy4, done4;
  logic [3:0] ci1, ci4;
  logic [AW-1:0] r1_1, r1_2, r1_3, r1_4, r4_1, r4_2, r4_3, r4_4;

  int n_chk = 0, n_pass = 0, cyc = 0, cr_bad = 0;
  int sh1 = 0, sh4 = 0, dn1 = 0, dn4 = 0;
  bit fin1 = 0, fin4 = 0;
  exp_t q1[$], q4[$];
  vec_t tbl[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  x_mac_column #(.N_COLS(1), .ACC_W(AW)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .x_r1(x1), .x_r2(x2), .x_r3(x3), .x_r4(x4),
    .coef(coef), .coef_valid(coef_valid),
    .x_shift(xs1), .coef_ready(cr1),
    .res_r1(r1_1), .res_r2(r1_2), .res_r3(r1_3), .res_r4(r1_4),
    .res_valid(rv1), .col_idx(ci1), .busy(busy1), .done(done1)
  );

  x_mac_column #(.N_COLS(4), .ACC_W(AW)) dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .x_r1(x1), .x_r2(x2), .x_r3(x3), .x_r4(x4),
    .coef(coef), .coef_valid(coef_valid),
    .x_shift(xs4), .coef_ready(cr4),
    .res_r1(r4_1), .res_r2(r4_2), .res_r3(r4_3), .res_r4(r4_4),
    .res_valid(rv4), .col_idx(ci4), .busy(busy4), .done(done4)
  );

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  function automatic void fail_now(input string name);
    n_chk++;
    $display("FAIL %s", name);
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c, input int d, input int cf,
                              input bit st, input int sb, input int lat,
                              input int e1, input int e2, input int e3, input int e4);
    vec_t v;
    v.x[0] = 8'(a); v.x[1] = 8'(b); v.x[2] = 8'(c); v.x[3] = 8'(d);
    v.c = 8'(cf); v.stall = st; v.sbusy = sb; v.lat = lat;
    v.r[0] = AW'(e1); v.r[1] = AW'(e2); v.r[2] = AW'(e3); v.r[3] = AW'(e4);
    return v;
  endfunction

  task automatic on_result(input int d, input logic [3:0][AW-1:0] got, input logic [3:0] gi,
                           input logic gd);
    exp_t e;
    if (d == 1) begin
      if (q1.size() == 0) begin fail_now("dut1 unexpected res_valid"); return; end
      e = q1.pop_front();
    end else begin
      if (q4.size() == 0) begin fail_now("dut4 unexpected res_valid"); return; end
      e = q4.pop_front();
    end
    $display("dut%0d col %0d: %0d %0d %0d %0d done=%0b at cycle %0d",
             d, gi, got[0], got[1], got[2], got[3], gd, cyc);
    for (int i = 0; i < 4; i++)
      chk($sformatf("dut%0d col%0d row%0d", d, e.idx, i + 1), got[i], e.r[i]);
    chk($sformatf("dut%0d col_idx", d), gi, e.idx);
    chk($sformatf("dut%0d col%0d done", d, e.idx), gd, e.last);
    chk($sformatf("dut%0d col%0d cycle", d, e.idx), cyc, e.cyc);
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      if (xs1 !== cr1 || xs4 !== cr4) cr_bad++;
      if (xs1) sh1++;
      if (xs4) sh4++;
      if (done1) begin dn1++; fin1 = 1; end
      if (done4) begin dn4++; fin4 = 1; end
      if (rv1) on_result(1, {r1_4, r1_3, r1_2, r1_1}, ci1, done1);
      if (rv4) on_result(4, {r4_4, r4_3, r4_2, r4_1}, ci4, done4);
    end
  end

  task automatic run1(input vec_t v, input int n);
    exp_t e;
    @(posedge clk); #1;
    x1 = v.x[0]; x2 = v.x[1]; x3 = v.x[2]; x4 = v.x[3];
    coef = v.c; coef_valid = 1'b0; start1 = 1'b1;
    sh1 = 0; dn1 = 0; fin1 = 0;
    e.r = v.r; e.idx = 4'd0; e.last = 1'b1; e.cyc = cyc + v.lat;
    q1.push_back(e);
    for (int t = 1; t < 100 && !fin1; t++) begin
      @(posedge clk); #1;
      start1 = (t == v.sbusy);
      coef_valid = v.stall ? (t % 2 == 1) : 1'b1;
    end
    coef_valid = 1'b0; start1 = 1'b0;
    if (!fin1) fail_now($sformatf("vec%0d timeout", n));
    repeat (2) @(posedge clk); #1;
    chk($sformatf("vec%0d shifts", n), sh1, 8);
    chk($sformatf("vec%0d done pulses", n), dn1, 1);
    chk($sformatf("vec%0d leftover", n), q1.size(), 0);
    chk($sformatf("vec%0d hold", n), r1_1, v.r[0]);
  endtask

  task automatic run4(input string tag);
    exp_t e;
    @(posedge clk); #1;
    x1 = 8'd1; x2 = 8'd1; x3 = 8'd1; x4 = 8'd1;
    coef = 8'd0; coef_valid = 1'b0; start4 = 1'b1;
    sh4 = 0; dn4 = 0; fin4 = 0;
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 4; i++) e.r[i] = AW'(8 * (j + 1));
      e.idx = 4'(j); e.last = (j == 3); e.cyc = cyc + 9 + 8 * j;
      q4.push_back(e);
    end
    for (int t = 1; t < 100 && !fin4; t++) begin
      @(posedge clk); #1;
      start4 = 1'b0; coef_valid = 1'b1; coef = 8'((t - 1) / 8 + 1);
    end
    coef_valid = 1'b0;
    if (!fin4) fail_now($sformatf("%s timeout", tag));
    repeat (2) @(posedge clk); #1;
    chk($sformatf("%s shifts", tag), sh4, 32);
    chk($sformatf("%s done pulses", tag), dn4, 1);
    chk($sformatf("%s leftover", tag), q4.size(), 0);
  endtask

  initial begin
    exp_t e;
    tbl[0] = mk(1, 2, 3, 4, 2, 0, 0, 9, 16, 32, 48, 64);
    tbl[1] = mk(255, 255, 255, 255, 255, 0, 0, 9, 520200, 520200, 520200, 520200);
    tbl[2] = mk(3, 3, 3, 3, 5, 1, 0, 16, 120, 120, 120, 120);
    tbl[3] = mk(10, 20, 30, 40, 7, 0, 4, 9, 560, 1120, 1680, 2240);
    tbl[4] = mk(0, 255, 1, 128, 200, 1, 6, 16, 0, 408000, 1600, 204800);

    #2 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("reset dut1 res", r1_1 | r1_2 | r1_3 | r1_4, 0);
    chk("reset dut1 ctl", {ci1, rv1, done1, busy1, xs1}, 0);
    chk("reset dut4 res", r4_1 | r4_2 | r4_3 | r4_4, 0);
    chk("reset dut4 ctl", {ci4, rv4, done4, busy4, xs4}, 0);
    rst = 1'b1;

    for (int n = 0; n < 5; n++) run1(tbl[n], n);

    run4("cols4");

    // Reset during column 1 at k=5: column 0 is reported, column 1 never is
    @(posedge clk); #1;
    x1 = 8'd1; x2 = 8'd1; x3 = 8'd1; x4 = 8'd1;
    coef_valid = 1'b0; start4 = 1'b1; sh4 = 0;
    for (int i = 0; i < 4; i++) e.r[i] = AW'(8);
    e.idx = 4'd0; e.last = 1'b0; e.cyc = cyc + 9;
    q4.push_back(e);
    for (int t = 1; t <= 13; t++) begin
      @(posedge clk); #1;
      start4 = 1'b0; coef_valid = 1'b1; coef = 8'((t - 1) / 8 + 1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("mid reset res", r4_1 | r4_2 | r4_3 | r4_4, 0);
    chk("mid reset ctl", {ci4, rv4, done4, busy4, xs4}, 0);
    chk("mid reset leftover", q4.size(), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (12) @(posedge clk); #1;
    chk("mid reset shifts", sh4, 13);
    coef_valid = 1'b0;

    run4("fresh after reset");

    chk("coef_ready tracks x_shift", cr_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/x_mac_column.md
Name: x_mac_column

Overview:
- Downstream consumer of the four-row X shift buffer.
- After the buffer reports load complete, this block rotates the buffer one column per cycle with `x_shift` and multiplies the four presented X bytes by a streamed coefficient byte.
- Each product is accumulated over 8 columns, giving one 4-element result column (P[r][j] = sum over k of X[r][k]*A[k][j]) for each of `N_COLS` coefficient columns.

Parameters:
- `N_COLS`, 4: number of output columns j computed per start; legal range 1..16.
- `ACC_W`, 19: accumulator/result width; must be >= 19 (8 x 255 x 255 = 520200).

Ports:
- `clk`  in  1  single clock; rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level/pulse from the buffer's load-done flag; sampled only in IDLE.
- `x_r1`  in  8  current column byte, row 1.
- `x_r2`  in  8  current column byte, row 2.
- `x_r3`  in  8  current column byte, row 3.
- `x_r4`  in  8  current column byte, row 4.
- `coef`  in  8  coefficient A[k][j], unsigned.
- `coef_valid`  in  1  `coef` is valid this cycle.
- `x_shift`  out  1  rotate X buffer; asserted in exactly the cycles a product is consumed.
- `coef_ready`  out  1  same value as `x_shift` (coefficient consumed).
- `res_r1`  out  ACC_W  result row 1.
- `res_r2`  out  ACC_W  result row 2.
- `res_r3`  out  ACC_W  result row 3.
- `res_r4`  out  ACC_W  result row 4.
- `res_valid`  out  1  one-cycle pulse; `res_r*` hold column `col_idx`.
- `col_idx`  out  4  index of the column currently shown on `res_r*`.
- `busy`  out  1  high in ACCUM.
- `done`  out  1  one-cycle pulse after the last column.

Behaviour:
- Reset (async, `rst`=0): state IDLE; k counter=0; column counter=0; acc1..4=0; `res_r*`=0; `col_idx`=0; `res_valid`=0; `done`=0; `busy`=0; `x_shift`=0.
- All arithmetic is unsigned. Each product is 8x8 -> 16 bits, zero-extended to ACC_W. No saturation; the width rule guarantees no overflow.
- IDLE:
  - `x_shift`=0.
  - `start`=1 -> ACCUM next cycle; k=0, column counter=0, accumulators=0.
- ACCUM:
  - `busy`=1.
  - `x_shift` = `coef_ready` = `coef_valid` (combinational).
  - When `coef_valid`=1, at the clock edge: acc_i <= acc_i + x_ri*coef, and k <= k+1.
  - When `coef_valid`=0: stall. Accumulators and k hold; no shift.
  - When k==7 and `coef_valid`=1 (8th product):
    - `res_r*` <= acc_i + x_ri*coef.
    - `col_idx` <= current column.
    - `res_valid` <= 1 for the next cycle only.
    - acc_i <= 0 and k <= 0.
    - The 8 rotations have returned X to column 0, ready for the next j.
  - If that was column `N_COLS`-1: state -> DONE and `done` <= 1 (same cycle as the final `res_valid`). Otherwise the column counter increments and the state stays in ACCUM; the next product may be consumed in the very next cycle (no bubble).
- DONE: one cycle. `x_shift`=0, `busy`=0. -> IDLE.
- `start` while in ACCUM or DONE is ignored.
- `start` held high continuously: a new run begins on the first IDLE cycle.
- `res_r*` and `col_idx` hold their values between `res_valid` pulses and across runs until overwritten.
- Reset mid-run: immediate return to reset values. The partial column is discarded and no `res_valid` is issued.
- Latency, no stalls:
  - First `x_shift` is 1 cycle after `start` is sampled.
  - Each column takes 8 cycles; `res_valid` follows the 8th `x_shift` by 1 cycle.
  - Total start -> `done` = 1 + 8*N_COLS cycles.

Test Plan:
- Basic column: `N_COLS`=1; x_r1..4 = 1,2,3,4 constant; coef=2 for 8 cycles -> `res_r*` = 16,32,48,64; `res_valid` and `done` both pulse at cycle 9 after start; exactly 8 `x_shift` pulses.
- Max values: x=255 all rows, coef=255 x8 -> every `res_r*` = 520200 (0x7F008); no wrap.
- Stalls: `coef_valid` toggles 1,0,1,0...; x=3, coef=5 -> `x_shift` only on valid cycles; result 120 after 8 valid beats; `res_valid` 16 cycles after start.
- Back-to-back columns: `N_COLS`=4; coef stream j+1 for column j; x=1 -> results 8,16,24,32; `col_idx` 0..3; `res_valid` pulses spaced exactly 8 cycles; `done` only with the last pulse; 32 `x_shift` pulses.
- Start while busy: pulse `start` at k=3 -> ignored; result and counts unchanged.
- Reset mid-run: `rst` low at k=5 of column 1 -> all outputs 0 immediately, no `res_valid`; a new `start` gives a correct fresh run.
